i2c_xfer_seq: RTL
=================

I2C_XFER_SEQ -- requirements
Module: i2c_xfer_seq

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 4096: max cycles waiting for eng_done per engine command.
REQ-002 pclk  in  1  sole clock; all state on rising edge.
REQ-003 preset  in  1  reset, synchronous, active-high.
REQ-004 req_valid  in  1  host transfer request.
REQ-005 req_ready  out  1  high only in IDLE; transfer accepted when req_valid&&req_ready.
REQ-006 req_rnw  in  1  1=register read, 0=register write.
REQ-007 req_dev_addr  in  7  7-bit target address.
REQ-008 req_reg_addr  in  8  target register index.
REQ-009 req_wdata  in  8  write data byte.
REQ-010 rsp_valid  out  1  response available; held until rsp_ready.
REQ-011 rsp_ready  in  1  host accepts response.
REQ-012 rsp_rdata  out  8  read byte (0x00 on writes or errors).
REQ-013 rsp_err  out  2  00 ok, 01 address NACK, 10 register/data NACK, 11 timeout.
REQ-014 eng_cmd_valid  out  1  command to byte engine; held until eng_cmd_ready.
REQ-015 eng_cmd_ready  in  1  engine accepts command.
REQ-016 eng_cmd  out  3  0 START, 1 RESTART, 2 WRITE, 3 READ_ACK, 4 READ_NACK, 5 STOP.
REQ-017 eng_wdata  out  8  byte for WRITE; stable while eng_cmd_valid.
REQ-018 eng_done  in  1  one-cycle pulse: accepted command finished on bus.
REQ-019 eng_nack  in  1  valid with eng_done after WRITE; 1=target NACKed.
REQ-020 eng_rdata  in  8  valid with eng_done after READ_*.
REQ-021 eng_abort  out  1  one-cycle pulse on timeout; engine returns bus to idle.
REQ-022 busy  out  1  high in every state except IDLE.

Function
REQ-023 States: IDLE, START, DEVW, REG, WDAT, RSTRT, DEVR, RDAT, STOP, RESP.
REQ-024 Write sequence: START, WRITE {dev,0}, WRITE reg, WRITE wdata, STOP, RESP.
REQ-025 Read sequence: START, WRITE {dev,0}, WRITE reg, RESTART, WRITE {dev,1}, READ_NACK, STOP, RESP.
REQ-026 Request fields registered at acceptance; later changes on req_* ignored.
REQ-027 eng_cmd_valid asserts the cycle after entering a command state (first: cycle after acceptance); eng_cmd/eng_wdata constant until handshake.
REQ-028 After handshake, eng_cmd_valid drops next cycle; FSM waits for eng_done, advances on the eng_done cycle; next command valid the following cycle.
REQ-029 eng_done arriving when no command outstanding is ignored.
REQ-030 eng_nack=1 after DEVW or DEVR -> go STOP, rsp_err=01; after REG or WDAT -> go STOP, rsp_err=10; STOP still issued.
REQ-031 rsp_rdata captures eng_rdata on RDAT eng_done.
REQ-032 Timeout counter clears on each command handshake, increments while awaiting eng_done (or eng_cmd_ready); reaching TIMEOUT_CYCLES-1 -> eng_abort pulse, rsp_err=11, go RESP directly (no STOP).
REQ-033 Timeout during STOP overrides a pending NACK code (11 reported).
REQ-034 RESP: rsp_valid=1; on rsp_ready go IDLE; req_ready rises the cycle after rsp handshake.
REQ-035 rsp_rdata, rsp_err hold stable while rsp_valid; cleared on entry to a new transfer.
REQ-036 Only one transfer in flight; no request accepted outside IDLE.

Reset
REQ-037 preset=1 at a pclk edge forces IDLE from any state, including mid-transfer, with no STOP issued.
REQ-038 Reset values: req_ready=1 (after reset released), rsp_valid=0, rsp_rdata=0x00, rsp_err=00, eng_cmd_valid=0, eng_cmd=0, eng_wdata=0x00, eng_abort=0, busy=0, timeout counter=0.
REQ-039 While preset=1, req_ready=0.

Verification
REQ-040 Write dev=0x50 reg=0x10 data=0xA5, engine always ACK -> commands START, WRITE 0xA0, WRITE 0x10, WRITE 0xA5, STOP; rsp_err=00, rsp_rdata=0x00.
REQ-041 Read dev=0x50 reg=0x22, engine returns 0x3C -> START, WRITE 0xA0, WRITE 0x22, RESTART, WRITE 0xA1, READ_NACK, STOP; rsp_rdata=0x3C, rsp_err=00.
REQ-042 Write, NACK on WRITE 0xA0 -> next command STOP, then rsp_err=01; NACK on data byte -> rsp_err=10.
REQ-043 TIMEOUT_CYCLES=16, engine never sends eng_done after START -> eng_abort single pulse 16 cycles after handshake, rsp_err=11, no STOP issued.
REQ-044 preset asserted during REG wait -> next cycle busy=0, eng_cmd_valid=0, rsp_valid=0; new request then completes normally.
REQ-045 rsp_ready held low 10 cycles -> rsp_valid/rsp_err/rsp_rdata stable, req_ready=0 throughout; req_valid held high is not accepted.

Source files
------------

// File: rtl/i2c_xfer_seq.sv
// I2C register-transfer sequencer: turns one host read/write request into the
// byte-engine command sequence and reports the outcome as a single response.
module i2c_xfer_seq #(
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic       pclk,
  input  logic       preset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_rnw,
  input  logic [6:0] req_dev_addr,
  input  logic [7:0] req_reg_addr,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_rdata,
  output logic [1:0] rsp_err,
  output logic       eng_cmd_valid,
  input  logic       eng_cmd_ready,
  output logic [2:0] eng_cmd,
  output logic [7:0] eng_wdata,
  input  logic       eng_done,
  input  logic       eng_nack,
  input  logic [7:0] eng_rdata,
  output logic       eng_abort,
  output logic       busy
);

  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  localparam logic [2:0] CMD_START     = 3'd0;
  localparam logic [2:0] CMD_RESTART   = 3'd1;
  localparam logic [2:0] CMD_WRITE     = 3'd2;
  localparam logic [2:0] CMD_READ_NACK = 3'd4;
  localparam logic [2:0] CMD_STOP      = 3'd5;

  typedef enum logic [3:0] {
    IDLE, START, DEVW, REG, WDAT, RSTRT, DEVR, RDAT, STOP, RESP
  } state_t;

  state_t        state;
  state_t        nxt_state;
  logic          pending;
  logic [TW-1:0] tmo;
  logic [6:0]    dev_q;
  logic [7:0]    reg_q;
  logic [7:0]    wdata_q;
  logic          rnw_q;
  logic          nack_seen;
  logic [1:0]    nxt_err;
  logic [2:0]    nxt_cmd;
  logic [7:0]    nxt_wdata;

  assign busy      = (state != IDLE);
  assign req_ready = (state == IDLE) && !preset;

  // Where the sequence goes when the outstanding command completes, and what it issues there.
  always_comb begin
    nxt_state = STOP;
    nack_seen = 1'b0;
    nxt_err   = 2'b00;
    nxt_cmd   = CMD_STOP;
    nxt_wdata = 8'h00;
    case (state)
      START: nxt_state = DEVW;
      DEVW: begin
        if (eng_nack) begin
          nack_seen = 1'b1;
          nxt_err   = 2'b01;
        end else begin
          nxt_state = REG;
        end
      end
      REG: begin
        if (eng_nack) begin
          nack_seen = 1'b1;
          nxt_err   = 2'b10;
        end else begin
          nxt_state = rnw_q ? RSTRT : WDAT;
        end
      end
      WDAT: begin
        nack_seen = eng_nack;
        nxt_err   = eng_nack ? 2'b10 : 2'b00;
      end
      RSTRT: nxt_state = DEVR;
      DEVR: begin
        if (eng_nack) begin
          nack_seen = 1'b1;
          nxt_err   = 2'b01;
        end else begin
          nxt_state = RDAT;
        end
      end
      RDAT:    nxt_state = STOP;
      STOP:    nxt_state = RESP;
      default: nxt_state = IDLE;
    endcase
    case (nxt_state)
      DEVW: begin
        nxt_cmd   = CMD_WRITE;
        nxt_wdata = {dev_q, 1'b0};
      end
      REG: begin
        nxt_cmd   = CMD_WRITE;
        nxt_wdata = reg_q;
      end
      WDAT: begin
        nxt_cmd   = CMD_WRITE;
        nxt_wdata = wdata_q;
      end
      RSTRT: nxt_cmd = CMD_RESTART;
      DEVR: begin
        nxt_cmd   = CMD_WRITE;
        nxt_wdata = {dev_q, 1'b1};
      end
      RDAT:    nxt_cmd = CMD_READ_NACK;
      default: nxt_cmd = CMD_STOP;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      state         <= IDLE;
      pending       <= 1'b0;
      tmo           <= '0;
      dev_q         <= 7'h00;
      reg_q         <= 8'h00;
      wdata_q       <= 8'h00;
      rnw_q         <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_rdata     <= 8'h00;
      rsp_err       <= 2'b00;
      eng_cmd_valid <= 1'b0;
      eng_cmd       <= CMD_START;
      eng_wdata     <= 8'h00;
      eng_abort     <= 1'b0;
    end else begin
      eng_abort <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            dev_q         <= req_dev_addr;
            reg_q         <= req_reg_addr;
            wdata_q       <= req_wdata;
            rnw_q         <= req_rnw;
            rsp_rdata     <= 8'h00;
            rsp_err       <= 2'b00;
            pending       <= 1'b0;
            tmo           <= '0;
            eng_cmd_valid <= 1'b1;
            eng_cmd       <= CMD_START;
            eng_wdata     <= 8'h00;
            state         <= START;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          // The watchdog covers both waiting for the handshake and waiting for completion.
          if (eng_cmd_valid && eng_cmd_ready) begin
            eng_cmd_valid <= 1'b0;
            pending       <= 1'b1;
            tmo           <= '0;
          end else if (pending && eng_done) begin
            pending <= 1'b0;
            tmo     <= '0;
            state   <= nxt_state;
            if (nack_seen) rsp_err <= nxt_err;
            if (state == RDAT) rsp_rdata <= eng_rdata;
            if (nxt_state == RESP) begin
              rsp_valid <= 1'b1;
            end else begin
              eng_cmd_valid <= 1'b1;
              eng_cmd       <= nxt_cmd;
              eng_wdata     <= nxt_wdata;
            end
          end else if (tmo == TMO_LAST) begin
            eng_abort     <= 1'b1;
            eng_cmd_valid <= 1'b0;
            pending       <= 1'b0;
            tmo           <= '0;
            rsp_err       <= 2'b11;
            rsp_rdata     <= 8'h00;
            rsp_valid     <= 1'b1;
            state         <= RESP;
          end else begin
            tmo <= tmo + 1'b1;
          end
        end
      endcase
    end
  end

endmodule
